mac_result_buf: RTL and testbench



---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_sfifo.sv | 56 +++++
 rtl/mac_result_buf.sv | 91 +++++++++
 tb/tb_mac_result_buf.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and elaboration-time helpers for the MAC result path.
package mac_pkg;

  localparam int RES_W = 8;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Number of results in one NxN output matrix.
  function automatic int frame_size(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/mac_sfifo.sv
// Generic synchronous FIFO. The occupancy counter is the single source of
// full/empty, so the pointers only need clog2(DEPTH) bits and wrap freely.
// Callers must not pop while empty or push while full without a pop.
module mac_sfifo
  import mac_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  localparam int PW   = clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy update; flush discards any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Storage write, no reset. When full with a pop, wr_ptr equals rd_ptr and
  // the head is read combinationally before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mac_result_buf.sv
// Result buffer behind the MAC systolic array: queues result bytes, tags the
// last element of each NxN matrix and flags results dropped on a full queue.
module mac_result_buf
  import mac_pkg::*;
#(
  parameter int W     = RES_W,
  parameter int N     = 2,
  parameter int DEPTH = 8,
  localparam int LW   = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          res_v_i,
  input  logic [W-1:0]  res_i,
  input  logic          flush_i,
  input  logic          out_ready_i,
  output logic          out_v_o,
  output logic [W-1:0]  out_data_o,
  output logic          out_last_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i,
  output logic [LW-1:0] level_o
);

  localparam int FRAME = frame_size(N);
  localparam int FCW   = (clog2(FRAME) > 0) ? clog2(FRAME) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FRAME - 1);

  logic           res_fire;
  logic           push;
  logic           pop;
  logic           flush;
  logic           full;
  logic           empty;
  logic           ovf_set;
  logic [FCW-1:0] fcnt;
  logic [W:0]     wr_entry;
  logic [W:0]     head;

  // Handshake and gating. Frame position tracks every offered result, so
  // dropped bytes still consume their slot and alignment is preserved.
  assign res_fire   = ena & res_v_i;
  assign out_v_o    = ena & ~empty;
  assign pop        = out_v_o & out_ready_i;
  assign push       = res_fire & (~full | pop);
  assign flush      = ena & flush_i;
  assign ovf_set    = res_fire & full & ~pop;
  assign wr_entry   = {(fcnt == FCNT_LAST), res_i};
  assign out_data_o = head[W-1:0];
  assign out_last_o = head[W];

  mac_sfifo #(
    .W     (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  // Frame position counter, wrapping at N*N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
    end else if (flush) begin
      fcnt <= '0;
    end else if (res_fire) begin
      if (fcnt == FCNT_LAST) fcnt <= '0;
      else                   fcnt <= fcnt + FCW'(1);
    end
  end

  // Sticky overflow flag; a new drop beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o <= 1'b0;
    end else if (ena) begin
      if (ovf_set)        ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_result_buf.sv
// Directed bench for mac_result_buf (W=8, N=2, DEPTH=8).
// Inputs change 1ns after posedge; outputs are compared 1ns later, before
// the next edge.
module tb_mac_result_buf;

  localparam int W     = 8;
  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          res_v_i;
  logic [W-1:0]  res_i;
  logic          flush_i;
  logic          out_ready_i;
  logic          out_v_o;
  logic [W-1:0]  out_data_o;
  logic          out_last_o;
  logic          ovf_o;
  logic          ovf_clr_i;
  logic [LW-1:0] level_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_result_buf #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .res_v_i     (res_v_i),
    .res_i       (res_i),
    .flush_i     (flush_i),
    .out_ready_i (out_ready_i),
    .out_v_o     (out_v_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i),
    .level_o     (level_o)
  );

  typedef struct {
    logic       ena;
    logic       res_v;
    logic [7:0] res;
    logic       flush;
    logic       ready;
    logic       clr;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_last;
    int         exp_lvl;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic v, input logic [7:0] d,
                              input logic fl, input logic rdy, input logic clr,
                              input logic xv, input logic [7:0] xd, input logic xl,
                              input int xlvl, input logic xo);
    vec_t r;
    r.ena = e; r.res_v = v; r.res = d; r.flush = fl; r.ready = rdy; r.clr = clr;
    r.exp_v = xv; r.exp_d = xd; r.exp_last = xl; r.exp_lvl = xlvl; r.exp_ovf = xo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs before the edge, then clock.
  task automatic cyc(input string tag, input vec_t v);
    ena = v.ena; res_v_i = v.res_v; res_i = v.res; flush_i = v.flush;
    out_ready_i = v.ready; ovf_clr_i = v.clr;
    #1;
    chk({tag, ".v"}, 32'(out_v_o), 32'(v.exp_v));
    if (v.exp_v) begin
      chk({tag, ".data"}, 32'(out_data_o), 32'(v.exp_d));
      chk({tag, ".last"}, 32'(out_last_o), 32'(v.exp_last));
    end
    chk({tag, ".level"}, 32'(level_o), 32'(v.exp_lvl));
    chk({tag, ".ovf"}, 32'(ovf_o), 32'(v.exp_ovf));
    @(posedge clk);
    #1;
  endtask

  logic [7:0] d3 [8];
  logic       l3 [8];
  logic [7:0] d4 [4];
  logic       l4 [4];

  initial begin
    // Frame tag table: ready low while four results arrive, then drain.
    tbl.push_back(mk(1, 1, 8'h11, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h22, 0, 0, 0, 1, 8'h11, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'h33, 0, 0, 0, 1, 8'h11, 0, 2, 0));
    tbl.push_back(mk(1, 1, 8'h44, 0, 0, 0, 1, 8'h11, 0, 3, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h11, 0, 4, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 1, 8'h11, 0, 4, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 1, 8'h22, 0, 3, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 1, 8'h33, 0, 2, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 1, 8'h44, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));

    // Reset held two cycles with a result offered.
    rst = 1'b1; ena = 1'b1; res_v_i = 1'b1; res_i = 8'h55;
    flush_i = 1'b0; out_ready_i = 1'b0; ovf_clr_i = 1'b0;
    @(posedge clk); #1;
    chk("rst.v", 32'(out_v_o), 32'd0);
    chk("rst.level", 32'(level_o), 32'd0);
    chk("rst.ovf", 32'(ovf_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("rst_rel", mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));

    foreach (tbl[i]) cyc($sformatf("frame[%0d]", i), tbl[i]);

    // Overflow: fill with 01..08, drop AA, clear, then full push+pop of CC.
    for (int i = 0; i < 8; i++)
      cyc($sformatf("fill[%0d]", i),
          mk(1, 1, 8'(i + 1), 0, 0, 0, (i > 0), 8'h01, 0, i, 0));
    cyc("drop_aa", mk(1, 1, 8'hAA, 0, 0, 0, 1, 8'h01, 0, 8, 0));
    cyc("ovf_set", mk(1, 0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 8, 1));
    cyc("full_pp", mk(1, 1, 8'hCC, 0, 1, 0, 1, 8'h01, 0, 8, 0));
    d3 = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hCC};
    l3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++)
      cyc($sformatf("drain3[%0d]", i),
          mk(1, 0, 8'h00, 0, 1, 0, 1, d3[i], l3[i], 8 - i, 0));
    cyc("push_bb", mk(1, 1, 8'hBB, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    cyc("push_dd", mk(1, 1, 8'hDD, 0, 0, 0, 1, 8'hBB, 0, 1, 0));
    cyc("pop_bb",  mk(1, 0, 8'h00, 0, 1, 0, 1, 8'hBB, 0, 2, 0));
    cyc("pop_dd",  mk(1, 0, 8'h00, 0, 1, 0, 1, 8'hDD, 1, 1, 0));
    cyc("idle3",   mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));

    // Enable stall with three entries queued.
    for (int i = 0; i < 3; i++)
      cyc($sformatf("stall_fill[%0d]", i),
          mk(1, 1, 8'(8'h51 + i), 0, 0, 0, (i > 0), 8'h51, 0, i, 0));
    for (int i = 0; i < 2; i++)
      cyc($sformatf("ena_lo[%0d]", i), mk(0, 1, 8'hEE, 0, 1, 0, 0, 8'h00, 0, 3, 0));
    cyc("ena_hi",   mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h51, 0, 3, 0));
    cyc("push_54",  mk(1, 1, 8'h54, 0, 0, 0, 1, 8'h51, 0, 3, 0));
    d4 = '{8'h51, 8'h52, 8'h53, 8'h54};
    l4 = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++)
      cyc($sformatf("drain5[%0d]", i),
          mk(1, 0, 8'h00, 0, 1, 0, 1, d4[i], l4[i], 4 - i, 0));
    cyc("idle5", mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));

    // Flush mid-frame with a coincident push and pop, then a fresh frame.
    cyc("pre_61", mk(1, 1, 8'h61, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    cyc("pre_62", mk(1, 1, 8'h62, 0, 0, 0, 1, 8'h61, 0, 1, 0));
    cyc("flush",  mk(1, 1, 8'h99, 1, 1, 0, 1, 8'h61, 0, 2, 0));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("post_fill[%0d]", i),
          mk(1, 1, 8'(8'h71 + i), 0, 0, 0, (i > 0), 8'h71, 0, i, 0));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("post_drain[%0d]", i),
          mk(1, 0, 8'h00, 0, 1, 0, 1, 8'(8'h71 + i), (i == 3), 4 - i, 0));
    cyc("idle6", mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));

    // Overflow coincident with clear keeps the flag; flush leaves it set.
    for (int i = 0; i < 8; i++)
      cyc($sformatf("fill6[%0d]", i),
          mk(1, 1, 8'(8'h81 + i), 0, 0, 0, (i > 0), 8'h81, 0, i, 0));
    cyc("drop_clr",   mk(1, 1, 8'hAA, 0, 0, 1, 1, 8'h81, 0, 8, 0));
    cyc("ovf_kept",   mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h81, 0, 8, 1));
    cyc("flush_ovf",  mk(1, 0, 8'h00, 1, 0, 0, 1, 8'h81, 0, 8, 1));
    cyc("after_fl",   mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
